tcls_recovery_ctrl: RTL
=======================

// Module: tcls_recovery_ctrl
// PURPOSE
// - Sequences recovery of the triple-core lockstep (TCLS) system after an unrecoverable discrepancy.
// - Sits beside the TCLS wrapper and consumes its s_unrec_err_o as s_discrepancy_i.
// - On a discrepancy it:
//   - gates new AHB transfers,
//   - drains outstanding data phases on the instruction and data buses,
//   - holds all three cores in reset for RST_CYCLES, then releases them.
// - Counts retries. Escalates to a sticky fatal state after MAX_RETRIES recoveries without a quiet window.
// PARAMETERS
// RST_CYCLES     16    cycles s_core_rst_o is held high per recovery (>=1)
// MAX_RETRIES    3     recoveries allowed before FATAL (>=1)
// QUIET_CYCLES   1024  error-free RUN cycles after which the retry count clears (>=1)
// DRAIN_TIMEOUT  256   max cycles in DRAIN before escalating to FATAL (>=1)
// PORTS
// s_clk_i          in   1   clock
// s_reset_i        in   1   synchronous, active-high reset
// s_discrepancy_i  in   1   unrecoverable discrepancy from the TCLS wrapper
// s_i_htrans_i     in   2   voted I-bus htrans, before gating
// s_i_hready_i     in   1   voted I-bus hready
// s_d_htrans_i     in   2   voted D-bus htrans, before gating
// s_d_hready_i     in   1   voted D-bus hready
// s_bus_gate_o     out  1   1 = force downstream htrans to IDLE on both buses
// s_core_rst_o     out  1   1 = hold all three cores in reset
// s_recovering_o   out  1   1 while in DRAIN, RESET or RELEASE
// s_fatal_o        out  1   sticky fatal indication
// s_retry_cnt_o    out  RW  recoveries since the last quiet window; RW = $clog2(MAX_RETRIES+1)
// BEHAVIOUR
// - Clock and reset: single clock. All outputs are registered and decoded from the state register.
// - s_reset_i (from any state, including mid-recovery), effective next edge:
//   - state = RUN; retry count, quiet count, drain count, reset count and dphase flags = 0.
//   - All outputs = 0.
// - Data-phase flags i_dph and d_dph, with x in {i,d}:
//   - if s_x_hready_i: x_dph <= s_x_htrans_i[1] & ~s_bus_gate_o
//   - otherwise x_dph holds its value.
// - RUN (gate=0, rst=0):
//   - The quiet counter increments each cycle, saturating at QUIET_CYCLES.
//   - When it reaches QUIET_CYCLES, the retry count clears to 0.
//   - On s_discrepancy_i:
//     - if retry==MAX_RETRIES -> FATAL;
//     - else -> DRAIN, retry+1, quiet counter cleared.
//   - Quiet-clear and discrepancy in the same cycle: the clear applies first, so retry becomes 1 and the next state is DRAIN.
// - DRAIN (gate=1, rst=0):
//   - When i_dph==0 and d_dph==0 -> RESET, with the reset counter cleared.
//   - Else, if the drain counter reaches DRAIN_TIMEOUT-1 -> FATAL.
//   - Minimum DRAIN residency is 1 cycle.
// - RESET (gate=1, rst=1):
//   - Counts RST_CYCLES cycles, then -> RELEASE.
//   - s_core_rst_o is high for exactly RST_CYCLES consecutive cycles.
// - RELEASE (gate=1, rst=0): one cycle, then -> RUN.
// - FATAL (gate=1, rst=1, fatal=1): absorbing; exits only on s_reset_i.
// - s_discrepancy_i is ignored in DRAIN, RESET, RELEASE and FATAL. The cores' own discrepancy flops are reset by s_core_rst_o.
// - Latency:
//   - discrepancy sampled at edge N -> s_bus_gate_o=1 and s_recovering_o=1 after edge N+1.
//   - Best case discrepancy -> cores running again = 1 + 1 + RST_CYCLES + 1 cycles.
// - s_retry_cnt_o never exceeds MAX_RETRIES and never wraps.
// TESTING
// - Idle buses, discrepancy pulse at t0:
//   - gate=1 at t0+1; rst=1 for exactly 16 cycles starting t0+2; RUN at t0+19.
//   - s_retry_cnt_o = 1.
// - D-bus write accepted (htrans=2'b10, hready=1), discrepancy the same cycle, then hready=0 for 5 cycles:
//   - DRAIN lasts until hready=1; s_core_rst_o stays 0 throughout the stall.
// - Four discrepancies, each issued 100 cycles after the previous recovery completes:
//   - retry_cnt = 1, 2, 3; the fourth -> s_fatal_o=1, s_core_rst_o=1 held until s_reset_i.
// - Discrepancy, recovery, 1024 quiet cycles, discrepancy: retry_cnt = 0, then 1; no FATAL.
// - hready held 0 for 256 cycles in DRAIN -> FATAL on cycle 256.
// - Assert s_reset_i during RESET -> all outputs 0 next cycle, state RUN, retry_cnt = 0.

Source files
------------

// File: rtl/tcls_recovery_ctrl.sv
// Recovery sequencer for the triple-core lockstep system: on an unrecoverable
// discrepancy it gates the buses, drains data phases, resets the cores and counts retries.
module tcls_recovery_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int MAX_RETRIES   = 3,
    parameter int QUIET_CYCLES  = 1024,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                               s_clk_i,
    input  logic                               s_reset_i,
    input  logic                               s_discrepancy_i,
    input  logic [1:0]                         s_i_htrans_i,
    input  logic                               s_i_hready_i,
    input  logic [1:0]                         s_d_htrans_i,
    input  logic                               s_d_hready_i,
    output logic                               s_bus_gate_o,
    output logic                               s_core_rst_o,
    output logic                               s_recovering_o,
    output logic                               s_fatal_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   s_retry_cnt_o
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int CW = $clog2(RST_CYCLES + 1);

    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
    localparam logic [QW-1:0] QUIET_MAX  = QW'(QUIET_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_RESET,
        S_RELEASE,
        S_FATAL
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   retry_q, retry_d, retry_base;
    logic [QW-1:0]   quiet_q, quiet_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [CW-1:0]   rstc_q,  rstc_d;
    logic            i_dph_q, i_dph_d;
    logic            d_dph_q, d_dph_d;

    // Only the NONSEQ/SEQ bit of htrans matters for tracking a data phase.
    logic unused_htrans;
    assign unused_htrans = s_i_htrans_i[0] ^ s_d_htrans_i[0];

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q <= S_RUN;
            retry_q <= '0;
            quiet_q <= '0;
            drain_q <= '0;
            rstc_q  <= '0;
            i_dph_q <= 1'b0;
            d_dph_q <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            quiet_q <= quiet_d;
            drain_q <= drain_d;
            rstc_q  <= rstc_d;
            i_dph_q <= i_dph_d;
            d_dph_q <= d_dph_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        retry_base = retry_q;
        quiet_d    = quiet_q;
        drain_d    = drain_q;
        rstc_d     = rstc_q;
        i_dph_d    = s_i_hready_i ? (s_i_htrans_i[1] & ~s_bus_gate_o) : i_dph_q;
        d_dph_d    = s_d_hready_i ? (s_d_htrans_i[1] & ~s_bus_gate_o) : d_dph_q;

        case (state_q)
            S_RUN: begin
                quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + 1'b1;
                // The quiet-window clear takes effect before a same-cycle discrepancy.
                if (quiet_d == QUIET_MAX) retry_base = '0;
                retry_d = retry_base;
                if (s_discrepancy_i) begin
                    if (retry_base == RETRY_MAX) begin
                        state_d = S_FATAL;
                    end else begin
                        state_d = S_DRAIN;
                        retry_d = retry_base + 1'b1;
                        quiet_d = '0;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (!i_dph_q && !d_dph_q) begin
                    state_d = S_RESET;
                    rstc_d  = '0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_FATAL;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_RESET: begin
                if (rstc_q == RST_LAST) state_d = S_RELEASE;
                else                    rstc_d  = rstc_q + 1'b1;
            end
            S_RELEASE: state_d = S_RUN;
            S_FATAL:   state_d = S_FATAL;
            default:   state_d = S_RUN;
        endcase
    end

    assign s_bus_gate_o   = (state_q != S_RUN);
    assign s_core_rst_o   = (state_q == S_RESET) || (state_q == S_FATAL);
    assign s_recovering_o = (state_q == S_DRAIN) || (state_q == S_RESET) || (state_q == S_RELEASE);
    assign s_fatal_o      = (state_q == S_FATAL);
    assign s_retry_cnt_o  = retry_q;

endmodule
